loop_nest_counter: RTL and testbench

Programmable nested-loop counter for the systolic-array controller, generalising the single wrap counter to `NUM_LEVELS` cascaded levels, each with its own terminal count. Level 0 is innermost: it advances on `inc`, and each level carries into the next when it wraps. A small run/idle FSM latches the bounds at `start` and pulses `done` when the whole nest completes. An auto-restart mode supports back-to-back tiles. It sits between instruction decode (which supplies bounds) and the address/enable generators (which consume the per-level counts).

---
 rtl/loop_ctr_pkg.sv | 14 +
 rtl/loop_level_counter.sv | 29 ++
 rtl/loop_nest_counter.sv | 91 +++++++++
 tb/tb_loop_nest_counter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_ctr_pkg.sv
// Shared types and defaults for the nested-loop counter: FSM state encoding and
// the per-level count width derived from the systolic-array size.
package loop_ctr_pkg;

    typedef enum logic {
        LS_IDLE = 1'b0,
        LS_RUN  = 1'b1
    } loop_state_e;

    localparam int SA_NUM = 16;

    localparam int LC_BIT_WIDTH = $clog2(SA_NUM) + 4;

endpackage

// File: rtl/loop_level_counter.sv
// One bounded wrap counter of the loop nest: counts 0..max_count inclusive,
// advancing on en and returning to 0 after the terminal count.
module loop_level_counter
    import loop_ctr_pkg::*;
#(
    parameter int BIT_WIDTH = LC_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 en,
    input  logic [BIT_WIDTH-1:0] max_count,
    output logic                 at_max,
    output logic [BIT_WIDTH-1:0] count
);

    assign at_max = (count == max_count);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_max ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/loop_nest_counter.sv
// Programmable nested-loop counter: NUM_LEVELS cascaded wrap counters (level 0
// innermost) under a run/idle FSM with latched bounds, done pulse and auto-restart.
module loop_nest_counter
    import loop_ctr_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int BIT_WIDTH  = LC_BIT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic                            clear,
    input  logic                            auto_restart,
    input  logic                            inc,
    input  logic [NUM_LEVELS*BIT_WIDTH-1:0] max_count,
    output logic [NUM_LEVELS*BIT_WIDTH-1:0] count,
    output logic [NUM_LEVELS-1:0]           at_max,
    output logic [NUM_LEVELS-1:0]           wrap,
    output logic                            last,
    output logic                            busy,
    output logic                            done
);

    loop_state_e                     state_q;
    loop_state_e                     state_d;
    logic [NUM_LEVELS*BIT_WIDTH-1:0] max_q;
    logic                            auto_q;
    logic [NUM_LEVELS-1:0]           carry;
    logic [NUM_LEVELS-1:0]           en;
    logic                            step;
    logic                            complete;
    logic                            clr;

    // A step only happens in RUN and loses to clear/start issued on the same cycle.
    assign busy     = (state_q == LS_RUN);
    assign step     = inc & busy & ~start & ~clear;
    assign last     = busy & (&at_max);
    assign complete = step & last;
    assign clr      = clear | start;

    assign carry[0] = 1'b1;
    for (genvar g = 1; g < NUM_LEVELS; g++) begin : g_carry
        assign carry[g] = carry[g-1] & at_max[g-1];
    end

    assign en   = {NUM_LEVELS{step}} & carry;
    assign wrap = en & at_max;

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_level
        loop_level_counter #(
            .BIT_WIDTH (BIT_WIDTH)
        ) u_level (
            .clk       (clk),
            .rstn      (rstn),
            .clr       (clr),
            .en        (en[g]),
            .max_count (max_q[g*BIT_WIDTH +: BIT_WIDTH]),
            .at_max    (at_max[g]),
            .count     (count[g*BIT_WIDTH +: BIT_WIDTH])
        );
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = LS_IDLE;
        end else if (start) begin
            state_d = LS_RUN;
        end else if (complete && !auto_q) begin
            state_d = LS_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LS_IDLE;
            max_q   <= '0;
            auto_q  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= complete;
            // Bounds and mode are captured only by a start that is not overridden by clear.
            if (start && !clear) begin
                max_q  <= max_count;
                auto_q <= auto_restart;
            end
        end
    end

endmodule

// File: tb/tb_loop_nest_counter.sv
// Randomised and directed bench for loop_nest_counter against a step-index model
// that derives per-level counts as mixed-radix digits of the position in the nest.
module tb_loop_nest_counter;

    localparam int L = 3;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start;
    logic           clear;
    logic           auto_restart;
    logic           inc;
    logic [L*W-1:0] max_count;
    logic [L*W-1:0] count;
    logic [L-1:0]   at_max;
    logic [L-1:0]   wrap;
    logic           last;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    loop_nest_counter #(
        .NUM_LEVELS (L),
        .BIT_WIDTH  (W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .clear        (clear),
        .auto_restart (auto_restart),
        .inc          (inc),
        .max_count    (max_count),
        .count        (count),
        .at_max       (at_max),
        .wrap         (wrap),
        .last         (last),
        .busy         (busy),
        .done         (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position k within the nest plus latched bounds
    int     m_max [L];
    bit     m_auto;
    bit     m_run;
    bit     m_done;
    longint m_k;

    function automatic longint radix(input int upto);
        longint p = 1;
        for (int j = 0; j < upto; j++) p = p * (m_max[j] + 1);
        return p;
    endfunction

    function automatic longint digit(input int i);
        return (m_k / radix(i)) % (m_max[i] + 1);
    endfunction

    function automatic logic [L*W-1:0] exp_count();
        logic [L*W-1:0] v;
        for (int i = 0; i < L; i++) v[i*W +: W] = W'(digit(i));
        return v;
    endfunction

    function automatic logic [L-1:0] exp_at_max();
        logic [L-1:0] v;
        for (int i = 0; i < L; i++) v[i] = (digit(i) == m_max[i]);
        return v;
    endfunction

    function automatic logic [L-1:0] exp_wrap();
        logic [L-1:0] v;
        for (int i = 0; i < L; i++)
            v[i] = inc && m_run && !start && !clear && (((m_k + 1) % radix(i + 1)) == 0);
        return v;
    endfunction

    function automatic logic exp_last();
        return m_run && (m_k == radix(L) - 1);
    endfunction

    function automatic logic [L*W-1:0] bounds(input int b0, input int b1, input int b2);
        return {W'(b2), W'(b1), W'(b0)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < L; i++) m_max[i] = 0;
        m_auto = 0;
        m_run  = 0;
        m_done = 0;
        m_k    = 0;
    endtask

    task automatic drive(input bit s, input bit c, input bit a, input bit i,
                         input logic [L*W-1:0] mc);
        start        = s;
        clear        = c;
        auto_restart = a;
        inc          = i;
        max_count    = mc;
        #1;
    endtask

    task automatic edge_t();
        bit dn;
        @(posedge clk);
        dn = 0;
        if (!rstn) begin
            model_reset();
        end else begin
            if (clear) begin
                m_run = 0;
                m_k   = 0;
            end else if (start) begin
                for (int i = 0; i < L; i++) m_max[i] = int'(max_count[i*W +: W]);
                m_auto = auto_restart;
                m_k    = 0;
                m_run  = 1;
            end else if (inc && m_run) begin
                if (m_k == radix(L) - 1) begin
                    m_k = 0;
                    dn  = 1;
                    if (!m_auto) m_run = 0;
                end else begin
                    m_k++;
                end
            end
            m_done = dn;
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(0, 0, 0, 0, '0);
        edge_t();
        edge_t();
        n_tests++;
        if (count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state count=%h busy=%b done=%b required count=0 busy=0 done=0",
                     count, busy, done);
        end
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 1, bounds(1, 1, 1));
            edge_t();
            n_tests++;
            if (count !== exp_count() || busy !== m_run || done !== m_done) begin
                n_fail++;
                $display("FAIL idle_inc c%0d count=%h busy=%b done=%b required %h %b %b",
                         c, count, busy, done, exp_count(), m_run, m_done);
            end
        end
    endtask

    task automatic test_single_nest();
        logic [L*W-1:0] mc = bounds(1, 2, 1);
        int nd = 0;
        drive(1, 0, 0, 0, mc);
        edge_t();
        for (int s = 1; s <= 12; s++) begin
            drive(0, 0, 0, 1, mc);
            n_tests++;
            if (at_max !== exp_at_max() || wrap !== exp_wrap() || last !== exp_last()) begin
                n_fail++;
                $display("FAIL single_comb s%0d at_max=%b wrap=%b last=%b required %b %b %b",
                         s, at_max, wrap, last, exp_at_max(), exp_wrap(), exp_last());
            end
            if (s == 12) begin
                n_tests++;
                if (wrap[2] !== 1'b1 || last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_final_wrap wrap=%b last=%b required wrap[2]=1 last=1",
                             wrap, last);
                end
            end
            edge_t();
            n_tests++;
            if (count !== exp_count() || busy !== m_run || done !== m_done) begin
                n_fail++;
                $display("FAIL single_regs s%0d count=%h busy=%b done=%b required %h %b %b",
                         s, count, busy, done, exp_count(), m_run, m_done);
            end
            if (done === 1'b1) nd++;
        end
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 0, mc);
            edge_t();
            if (done === 1'b1) nd++;
        end
        n_tests++;
        if (nd != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_pulse pulses=%0d busy=%b required pulses=1 busy=0", nd, busy);
        end
    endtask

    task automatic test_zero_bounds();
        logic [L*W-1:0] mc = bounds(0, 3, 0);
        drive(1, 0, 0, 0, mc);
        edge_t();
        for (int s = 1; s <= 4; s++) begin
            drive(0, 0, 0, 1, mc);
            n_tests++;
            if (wrap[0] !== 1'b1 || wrap !== exp_wrap() || last !== exp_last()) begin
                n_fail++;
                $display("FAIL zero_wrap s%0d wrap=%b last=%b required wrap=%b last=%b",
                         s, wrap, last, exp_wrap(), exp_last());
            end
            edge_t();
            n_tests++;
            if (count !== exp_count() || busy !== m_run || done !== m_done) begin
                n_fail++;
                $display("FAIL zero_regs s%0d count=%h busy=%b done=%b required %h %b %b",
                         s, count, busy, done, exp_count(), m_run, m_done);
            end
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done done=%b required 1", done);
        end
        drive(0, 0, 0, 0, mc);
        edge_t();
    endtask

    task automatic test_auto_restart();
        logic [L*W-1:0] mc = bounds(2, 1, 0);
        int ecount;
        int pos[$];
        drive(1, 0, 1, 0, mc);
        edge_t();
        ecount = 1;
        for (int s = 1; s <= 18; s++) begin
            drive(0, 0, 0, 1, mc);
            edge_t();
            ecount++;
            if (done === 1'b1) pos.push_back(ecount);
            n_tests++;
            if (count !== exp_count() || busy !== 1'b1 || done !== m_done) begin
                n_fail++;
                $display("FAIL auto_regs s%0d count=%h busy=%b done=%b required %h 1 %b",
                         s, count, busy, done, exp_count(), m_done);
            end
        end
        n_tests++;
        if (pos.size() != 3 || pos[0] != 7 || pos[1] != 13 || pos[2] != 19) begin
            n_fail++;
            $display("FAIL auto_done_cycles got %0d pulses %p required 3 pulses at 7 13 19",
                     pos.size(), pos);
        end
        drive(0, 1, 0, 0, mc);
        edge_t();
    endtask

    task automatic test_priority();
        logic [L*W-1:0] mc;
        mc = bounds(2, 2, 2);
        drive(1, 0, 0, 0, mc);
        edge_t();
        for (int s = 0; s < 5; s++) begin
            drive(0, 0, 0, 1, mc);
            edge_t();
        end
        drive(1, 1, 0, 1, bounds(1, 1, 1));
        edge_t();
        n_tests++;
        if (count !== '0 || busy !== 1'b0 || count !== exp_count() || busy !== m_run) begin
            n_fail++;
            $display("FAIL clear_start count=%h busy=%b required count=0 busy=0", count, busy);
        end
        mc = bounds(1, 1, 1);
        drive(1, 0, 0, 0, mc);
        edge_t();
        for (int s = 0; s < 3; s++) begin
            drive(0, 0, 0, 1, mc);
            edge_t();
        end
        mc = bounds(3, 0, 1);
        drive(1, 0, 0, 1, mc);
        n_tests++;
        if (wrap !== exp_wrap()) begin
            n_fail++;
            $display("FAIL start_inc_wrap wrap=%b required %b", wrap, exp_wrap());
        end
        edge_t();
        n_tests++;
        if (count !== '0 || busy !== 1'b1 || at_max !== exp_at_max()) begin
            n_fail++;
            $display("FAIL start_inc count=%h busy=%b at_max=%b required count=0 busy=1 at_max=%b",
                     count, busy, at_max, exp_at_max());
        end
        for (int s = 1; s <= 7; s++) begin
            drive(0, 0, 0, 1, mc);
            edge_t();
            n_tests++;
            if (count !== exp_count() || busy !== m_run || done !== m_done) begin
                n_fail++;
                $display("FAIL new_bounds s%0d count=%h busy=%b done=%b required %h %b %b",
                         s, count, busy, done, exp_count(), m_run, m_done);
            end
        end
        drive(0, 1, 0, 1, mc);
        n_tests++;
        if (last !== 1'b1 || last !== exp_last()) begin
            n_fail++;
            $display("FAIL clear_last_pre last=%b required 1", last);
        end
        edge_t();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL clear_on_complete done=%b busy=%b count=%h required 0 0 0",
                     done, busy, count);
        end
    endtask

    task automatic test_async_reset();
        logic [L*W-1:0] mc = bounds(1, 2, 1);
        int nd = 0;
        drive(1, 0, 0, 0, mc);
        edge_t();
        for (int s = 0; s < 3; s++) begin
            drive(0, 0, 0, 1, mc);
            edge_t();
        end
        n_tests++;
        if (count !== bounds(1, 1, 0)) begin
            n_fail++;
            $display("FAIL pre_reset_count count=%h required %h", count, bounds(1, 1, 0));
        end
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (count !== '0 || busy !== 1'b0 || done !== 1'b0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset count=%h busy=%b done=%b last=%b required all 0",
                     count, busy, done, last);
        end
        drive(0, 0, 0, 0, mc);
        #1;
        rstn = 1'b1;
        drive(0, 0, 0, 1, mc);
        edge_t();
        n_tests++;
        if (busy !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle busy=%b count=%h required 0 0", busy, count);
        end
        drive(1, 0, 0, 0, mc);
        edge_t();
        for (int s = 1; s <= 12; s++) begin
            drive(0, 0, 0, 1, mc);
            edge_t();
            if (done === 1'b1) nd++;
            n_tests++;
            if (count !== exp_count() || busy !== m_run || done !== m_done) begin
                n_fail++;
                $display("FAIL rerun s%0d count=%h busy=%b done=%b required %h %b %b",
                         s, count, busy, done, exp_count(), m_run, m_done);
            end
        end
        n_tests++;
        if (nd != 1) begin
            n_fail++;
            $display("FAIL rerun_done pulses=%0d required 1", nd);
        end
    endtask

    task automatic test_random();
        logic [L*W-1:0] mc;
        bit s, c, a, i;
        for (int cyc = 0; cyc < 400; cyc++) begin
            mc = bounds($urandom_range(3), $urandom_range(3), $urandom_range(3));
            s  = ($urandom_range(15) == 0);
            c  = ($urandom_range(31) == 0);
            a  = $urandom_range(1);
            i  = ($urandom_range(3) != 0);
            drive(s, c, a, i, mc);
            n_tests++;
            if (at_max !== exp_at_max() || wrap !== exp_wrap() || last !== exp_last()) begin
                n_fail++;
                $display("FAIL rand_comb c%0d at_max=%b wrap=%b last=%b required %b %b %b",
                         cyc, at_max, wrap, last, exp_at_max(), exp_wrap(), exp_last());
            end
            edge_t();
            n_tests++;
            if (count !== exp_count() || busy !== m_run || done !== m_done) begin
                n_fail++;
                $display("FAIL rand_regs c%0d count=%h busy=%b done=%b required %h %b %b",
                         cyc, count, busy, done, exp_count(), m_run, m_done);
            end
        end
    endtask

    initial begin
        rstn         = 1'b0;
        start        = 1'b0;
        clear        = 1'b0;
        auto_restart = 1'b0;
        inc          = 1'b0;
        max_count    = '0;
        model_reset();
        test_reset();
        test_single_nest();
        test_zero_bounds();
        test_auto_restart();
        test_priority();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
